sll_multicycle: RTL and testbench

- Iterative logical-left shifter: the left-shifting counterpart of the team's combinational arithmetic right shifter in the ALU.
- Applies one binary shift stage per clock (16, 8, 4, 2, 1) instead of a full combinational barrel, to relieve timing on the execute path.
- Sits beside the ALU; the execute stage stalls on busy and consumes the result when done pulses.
- Zero fill from the LSB side; bits shifted past the MSB are discarded.

---
 rtl/sll_multicycle.sv | 95 +++++++++
 tb/tb_sll_multicycle.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/sll_multicycle.sv
// Iterative logical-left shifter: one binary stage (2**k positions) per clock, MSB stage first.
// state | meaning
// IDLE  | waiting for start
// SHIFT | stage counter k runs SHW-1 down to 0, one conditional shift per clock
// DONE  | single cycle, out valid, may accept a back-to-back start
module sll_multicycle #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in,
  input  logic [SHW-1:0]   shamt,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done
);

  localparam int KW = (SHW > 1) ? $clog2(SHW) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] acc_stage;
  logic [SHW-1:0]   sh_q, sh_d;
  logic [KW-1:0]    k_q, k_d;

  // Each stage is a fixed-distance shift, so only a SHW-way mux sits in front of acc.
  always_comb begin
    acc_stage = acc_q;
    for (int i = 0; i < SHW; i++) begin
      if (k_q == KW'(i) && sh_q[i]) begin
        acc_stage = acc_q << (2 ** i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    sh_d    = sh_q;
    k_d     = k_q;
    out_d   = out_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          acc_d   = in;
          sh_d    = shamt;
          k_d     = KW'(SHW - 1);
          state_d = S_SHIFT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        acc_d = acc_stage;
        if (k_q == '0) begin
          out_d   = acc_stage;
          state_d = S_DONE;
        end else begin
          k_d = k_q - KW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      out_q   <= '0;
      sh_q    <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      sh_q    <= sh_d;
      k_q     <= k_d;
    end
  end

  assign out  = out_q;
  assign busy = (state_q == S_SHIFT);
  assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_sll_multicycle.sv
// Scoreboard bench for sll_multicycle: a timing/result model queues expected results, a negedge monitor checks them.
module tb_sll_multicycle;
  localparam int WIDTH = 32;
  localparam int SHW   = 5;

  logic             clock;
  logic             reset_n;
  logic             start;
  logic [WIDTH-1:0] din;
  logic [SHW-1:0]   sh;
  logic [WIDTH-1:0] dout;
  logic             busy;
  logic             done;

  int total = 0;
  int bad   = 0;

  sll_multicycle #(.WIDTH(WIDTH), .SHW(SHW)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .start  (start),
    .in     (din),
    .shamt  (sh),
    .out    (dout),
    .busy   (busy),
    .done   (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an accepted request occupies SHW cycles, then one result cycle.
  typedef struct {
    logic [WIDTH-1:0] res;
    int               acc_cyc;
  } exp_t;

  exp_t             sb_q[$];
  int               cyc = 0;
  int               busy_left = 0;
  logic             exp_done = 1'b0;
  logic [WIDTH-1:0] exp_out = '0;
  logic [WIDTH-1:0] pending = '0;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy_left = 0;
      exp_done  = 1'b0;
      exp_out   = '0;
      sb_q.delete();
    end else begin
      cyc++;
      if (busy_left > 0) begin
        busy_left--;
        exp_done = (busy_left == 0);
        if (busy_left == 0) exp_out = pending;
      end else begin
        exp_done = 1'b0;
        if (start) begin
          pending = din << sh;
          sb_q.push_back('{pending, cyc});
          busy_left = SHW;
        end
      end
    end
  end

  always @(negedge clock) begin
    exp_t e;
    chk("busy", 64'(busy), 64'(busy_left > 0));
    chk("done", 64'(done), 64'(exp_done));
    chk("out_hold", 64'(dout), 64'(exp_out));
    if (done) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_pop: done with no expected result at %0t", $time);
      end else begin
        e = sb_q.pop_front();
        chk("sb_out", 64'(dout), 64'(e.res));
        chk("latency", 64'(cyc - e.acc_cyc), 64'(SHW));
      end
    end
  end

  task automatic do_op(input logic [WIDTH-1:0] a, input logic [SHW-1:0] s,
                       input logic [WIDTH-1:0] expv, input bit directed);
    @(negedge clock);
    start = 1'b1;
    din   = a;
    sh    = s;
    @(negedge clock);
    start = 1'b0;
    din   = $urandom;
    sh    = SHW'($urandom);
    repeat (SHW) @(negedge clock);
    if (directed) begin
      chk("directed_out", 64'(dout), 64'(expv));
      chk("directed_done", 64'(done), 64'(1));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    reset_n = 1'b0;
    start   = 1'b1;
    din     = 32'hDEAD_BEEF;
    sh      = 5'd7;
    repeat (3) @(negedge clock);
    chk("rst_out", 64'(dout), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    reset_n = 1'b1;
    start   = 1'b0;
    repeat (10) begin
      @(negedge clock);
      chk("idle_out", 64'(dout), 64'(0));
      chk("idle_busy", 64'(busy), 64'(0));
    end

    do_op(32'h0000_0001, 5'd31, 32'h8000_0000, 1'b1);
    do_op(32'hFFFF_FFFF, 5'd21, 32'hFFE0_0000, 1'b1);
    do_op(32'h1234_5678, 5'd4,  32'h2345_6780, 1'b1);
    do_op(32'h1234_5678, 5'd0,  32'h1234_5678, 1'b1);

    // start pulsed mid-SHIFT with a different operand must be ignored
    @(negedge clock);
    start = 1'b1; din = 32'h11; sh = 5'd2;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    @(negedge clock);
    start = 1'b1; din = 32'hFFFF; sh = 5'd7;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("ignored_start_out", 64'(dout), 64'(32'h44));
    chk("ignored_start_done", 64'(done), 64'(1));
    repeat (2) @(negedge clock);

    // continuous start: one result every SHW+1 cycles
    @(negedge clock);
    start = 1'b1; din = 32'h3; sh = 5'd1;
    cnt = 0;
    repeat (6 * 5) begin
      @(negedge clock);
      if (done) begin
        cnt++;
        chk("b2b_out", 64'(dout), 64'(32'h6));
      end
    end
    chk("b2b_count", 64'(cnt), 64'(5));
    start = 1'b0;
    repeat (8) @(negedge clock);

    // reset during the 3rd SHIFT cycle abandons the operation
    start = 1'b1; din = 32'hA; sh = 5'd3;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_out", 64'(dout), 64'(0));
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_done", 64'(done), 64'(0));
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (6) begin
      @(negedge clock);
      chk("midrst_no_done", 64'(done), 64'(0));
    end
    do_op(32'hA, 5'd3, 32'h50, 1'b1);

    for (int i = 0; i < 1000; i++) begin
      do_op($urandom, SHW'($urandom_range(0, 31)), '0, 1'b0);
      if ($urandom_range(0, 3) == 0) @(negedge clock);
    end
    repeat (3) @(negedge clock);
    chk("sb_empty", 64'(sb_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
